// File: rtl/dmrs_slot_mapper.sv
`default_nettype none
// dmrs_slot_mapper: buffers one NB-IoT DMRS row and interleaves it with modulator data into SC-FDMA slot(s).
// Build option DMRS_SLOT_PAIR_EN: two slots per start, out_sym carries the slot index as MSB.  Rev 1.0
module dmrs_slot_mapper #(
  parameter int DW       = 32,
  parameter int NSYM     = 7,
  parameter int DMRS_SYM = 3,
  parameter int MAX_SC   = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    Nsc,
  input  logic          dmrs_valid,
  input  logic [DW-1:0] dmrs_real,
  input  logic [DW-1:0] dmrs_img,
  input  logic          dmrs_done,
  input  logic          data_valid,
  output logic          data_ready,
  input  logic [DW-1:0] data_real,
  input  logic [DW-1:0] data_img,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_img,
`ifdef DMRS_SLOT_PAIR_EN
  output logic [3:0]    out_sym,
`else
  output logic [2:0]    out_sym,
`endif
  output logic [3:0]    out_sc,
  output logic          slot_done,
  output logic          cfg_err
);

  localparam int SW = 3;
`ifdef DMRS_SLOT_PAIR_EN
  localparam int OSW = SW + 1;
`else
  localparam int OSW = SW;
`endif

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_LOAD = 2'd1;
  localparam logic [1:0] C_MAP  = 2'd2;
  localparam logic [1:0] C_DONE = 2'd3;

  localparam logic [SW-1:0] C_DMRS_SYM = SW'(DMRS_SYM);
  localparam logic [SW-1:0] C_LAST_SYM = SW'(NSYM - 1);

  logic [1:0]      state_q, state_d;
  logic [3:0]      nsc_q;
  logic [3:0]      wr_ptr_q;
  logic [2*DW-1:0] mem_q [MAX_SC];

  // Load-side position: which (slot, sym, sc) goes into the output register next.
  logic [SW-1:0]   ld_sym_q;
  logic [3:0]      ld_sc_q;
  logic            ld_done_q;
`ifdef DMRS_SLOT_PAIR_EN
  logic            ld_slot_q;
`endif

  logic            out_valid_q;
  logic [DW-1:0]   out_real_q;
  logic [DW-1:0]   out_img_q;
  logic [OSW-1:0]  out_sym_q;
  logic [3:0]      out_sc_q;
  logic            slot_done_q;
  logic            cfg_err_q;

  logic            w_nsc_legal;
  logic            w_start_ok;
  logic            w_start_bad;
  logic            w_wr;
  logic [3:0]      w_wr_ptr_nxt;
  logic            w_load_full;
  logic [3:0]      w_nsc_m1;
  logic            w_free;
  logic            w_hs;
  logic            w_ld_dmrs_sym;
  logic            w_ld_data;
  logic            w_ld_dmrs;
  logic            w_ld;
  logic            w_ld_last_sc;
  logic            w_ld_last_sym;
  logic            w_ld_last_slot;
  logic            w_out_last;
  logic            w_slot_end;
  logic            w_frame_end;
  logic [2*DW-1:0] w_mem_rd;
  logic [OSW-1:0]  w_ld_sym_tag;

  assign w_nsc_legal   = (Nsc == 4'd1) || (Nsc == 4'd3) || (Nsc == 4'd6) ||
                         ((Nsc == 4'd12) && (MAX_SC >= 12));
  assign w_nsc_m1      = nsc_q - 4'd1;
  assign w_wr          = (state_q == C_LOAD) && dmrs_valid && (wr_ptr_q < nsc_q);
  assign w_wr_ptr_nxt  = wr_ptr_q + {3'd0, w_wr};
  assign w_load_full   = (w_wr_ptr_nxt == nsc_q);
  assign w_free        = !out_valid_q || out_ready;
  assign w_hs          = out_valid_q && out_ready;
  assign w_ld_dmrs_sym = (ld_sym_q == C_DMRS_SYM);
  assign w_ld_last_sc  = (ld_sc_q == w_nsc_m1);
  assign w_ld_last_sym = (ld_sym_q == C_LAST_SYM);
  assign w_out_last    = (out_sc_q == w_nsc_m1) && (out_sym_q[SW-1:0] == C_LAST_SYM);
  assign w_slot_end    = (state_q == C_MAP) && w_hs && w_out_last;
  assign w_ld          = w_ld_data || w_ld_dmrs;
  assign w_mem_rd      = mem_q[ld_sc_q];

`ifdef DMRS_SLOT_PAIR_EN
  assign w_ld_last_slot = ld_slot_q;
  assign w_frame_end    = w_slot_end && out_sym_q[SW];
  assign w_ld_sym_tag   = {ld_slot_q, ld_sym_q};
`else
  assign w_ld_last_slot = 1'b1;
  assign w_frame_end    = w_slot_end;
  assign w_ld_sym_tag   = ld_sym_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= C_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE: if (start && w_nsc_legal) state_d = C_LOAD;
      C_LOAD: begin
        if (w_load_full) begin
          state_d = C_MAP;
        end else if (dmrs_done) begin
          state_d = C_IDLE;
        end
      end
      C_MAP:  if (w_frame_end) state_d = C_DONE;
      C_DONE: state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    data_ready  = 1'b0;
    w_ld_data   = 1'b0;
    w_ld_dmrs   = 1'b0;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    case (state_q)
      C_IDLE: begin
        w_start_ok  = start && w_nsc_legal;
        w_start_bad = start && !w_nsc_legal;
      end
      C_MAP: begin
        data_ready = !ld_done_q && !w_ld_dmrs_sym && w_free;
        w_ld_data  = data_ready && data_valid;
        w_ld_dmrs  = !ld_done_q && w_ld_dmrs_sym && w_free;
      end
      default: ;
    endcase
  end

  // DMRS row storage; contents are only meaningful after a complete LOAD.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= {dmrs_real, dmrs_img};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nsc_q       <= 4'd0;
      wr_ptr_q    <= 4'd0;
      ld_sym_q    <= '0;
      ld_sc_q     <= 4'd0;
      ld_done_q   <= 1'b0;
`ifdef DMRS_SLOT_PAIR_EN
      ld_slot_q   <= 1'b0;
`endif
      out_valid_q <= 1'b0;
      out_real_q  <= '0;
      out_img_q   <= '0;
      out_sym_q   <= '0;
      out_sc_q    <= 4'd0;
      slot_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      slot_done_q <= w_slot_end;
      cfg_err_q   <= w_start_bad || ((state_q == C_LOAD) && dmrs_done && !w_load_full);

      if (w_start_ok) begin
        nsc_q     <= Nsc;
        wr_ptr_q  <= 4'd0;
        ld_sym_q  <= '0;
        ld_sc_q   <= 4'd0;
        ld_done_q <= 1'b0;
`ifdef DMRS_SLOT_PAIR_EN
        ld_slot_q <= 1'b0;
`endif
      end

      if (w_wr) begin
        wr_ptr_q <= w_wr_ptr_nxt;
      end

      if (w_ld) begin
        out_valid_q <= 1'b1;
        out_sym_q   <= w_ld_sym_tag;
        out_sc_q    <= ld_sc_q;
        if (w_ld_dmrs) begin
          out_real_q <= w_mem_rd[2*DW-1:DW];
          out_img_q  <= w_mem_rd[DW-1:0];
        end else begin
          out_real_q <= data_real;
          out_img_q  <= data_img;
        end
        if (w_ld_last_sc) begin
          ld_sc_q <= 4'd0;
          if (w_ld_last_sym) begin
            ld_sym_q <= '0;
            if (w_ld_last_slot) begin
              ld_done_q <= 1'b1;
            end
`ifdef DMRS_SLOT_PAIR_EN
            ld_slot_q <= 1'b1;
`endif
          end else begin
            ld_sym_q <= ld_sym_q + 3'd1;
          end
        end else begin
          ld_sc_q <= ld_sc_q + 4'd1;
        end
      end else if (w_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_real  = out_real_q;
  assign out_img   = out_img_q;
  assign out_sym   = out_sym_q;
  assign out_sc    = out_sc_q;
  assign slot_done = slot_done_q;
  assign cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmrs_slot_mapper.sv
`default_nettype none
// tb_dmrs_slot_mapper: directed + randomized checks of dmrs_slot_mapper against an arithmetic slot-layout model.
module tb_dmrs_slot_mapper;
  localparam int DW       = 32;
  localparam int NSYM     = 7;
  localparam int DMRS_SYM = 3;
  localparam int MAX_SC   = 12;
`ifdef DMRS_SLOT_PAIR_EN
  localparam int NSLOT = 2;
  localparam int OSW   = 4;
`else
  localparam int NSLOT = 1;
  localparam int OSW   = 3;
`endif
  localparam int NDAT  = NSLOT * NSYM * MAX_SC;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    Nsc = 4'd0;
  logic          dmrs_valid = 1'b0;
  logic [DW-1:0] dmrs_real = '0;
  logic [DW-1:0] dmrs_img = '0;
  logic          dmrs_done = 1'b0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [DW-1:0] data_real = '0;
  logic [DW-1:0] data_img = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_img;
  logic [OSW-1:0] out_sym;
  logic [3:0]    out_sc;
  logic          slot_done;
  logic          cfg_err;

  always #5 clk = ~clk;

  dmrs_slot_mapper #(.DW(DW), .NSYM(NSYM), .DMRS_SYM(DMRS_SYM), .MAX_SC(MAX_SC)) dut (
    .clk(clk), .reset(reset), .start(start), .Nsc(Nsc),
    .dmrs_valid(dmrs_valid), .dmrs_real(dmrs_real), .dmrs_img(dmrs_img), .dmrs_done(dmrs_done),
    .data_valid(data_valid), .data_ready(data_ready), .data_real(data_real), .data_img(data_img),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_img(out_img),
    .out_sym(out_sym), .out_sc(out_sc), .slot_done(slot_done), .cfg_err(cfg_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] dm_re [MAX_SC];
  logic [DW-1:0] dm_im [MAX_SC];
  logic [DW-1:0] dat_re [NDAT];
  logic [DW-1:0] dat_im [NDAT];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slot layout: beat b -> (slot, sym, sc); DMRS row at DMRS_SYM, data consumed in order elsewhere.
  function automatic logic [63:0] exp_iq(input int b, input int nsc);
    int per, slot, r, sym, sc, di;
    per  = NSYM * nsc;
    slot = b / per;
    r    = b % per;
    sym  = r / nsc;
    sc   = r % nsc;
    if (sym == DMRS_SYM) return {dm_re[sc], dm_im[sc]};
    di = slot * (NSYM - 1) * nsc + ((sym < DMRS_SYM) ? sym : sym - 1) * nsc + sc;
    return {dat_re[di], dat_im[di]};
  endfunction

  function automatic int exp_sym(input int b, input int nsc);
    return (b / (NSYM * nsc)) * 8 + (b % (NSYM * nsc)) / nsc;
  endfunction

  task automatic fill_counter();
    for (int k = 0; k < MAX_SC; k++) begin
      dm_re[k] = 32'(k + 1);
      dm_im[k] = -32'(k + 1);
    end
    for (int i = 0; i < NDAT; i++) begin
      dat_re[i] = 32'h1000 + 32'(i);
      dat_im[i] = 32'h2000 + 32'(i);
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < MAX_SC; k++) begin
      dm_re[k] = $urandom;
      dm_im[k] = $urandom;
    end
    for (int i = 0; i < NDAT; i++) begin
      dat_re[i] = $urandom;
      dat_im[i] = $urandom;
    end
  endtask

  task automatic do_start(input logic [3:0] n);
    @(negedge clk);
    start = 1'b1;
    Nsc   = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_dmrs(input int n_send, input bit done_with_last);
    for (int k = 0; k < n_send; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      dmrs_valid = 1'b1;
      dmrs_real  = dm_re[k];
      dmrs_img   = dm_im[k];
      dmrs_done  = done_with_last && (k == n_send - 1);
      @(negedge clk);
      dmrs_valid = 1'b0;
      dmrs_done  = 1'b0;
    end
    if (!done_with_last) begin
      dmrs_done = 1'b1;
      @(negedge clk);
      dmrs_done = 1'b0;
    end
  endtask

  task automatic watch(input int ncyc, output int n_err, output int n_val, output int n_rdy);
    n_err = 0;
    n_val = 0;
    n_rdy = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (cfg_err) n_err++;
      if (out_valid) n_val++;
      if (data_ready) n_rdy++;
      @(negedge clk);
    end
  endtask

  // rmode: 0 always ready, 1 toggling, 2 random.  dmode: 0 data always offered, 1 random.
  task automatic run_slot(input int nsc, input int rmode, input int dmode, input int abort_at,
                          output bit aborted);
    int beats, dp, pulses, cyc, total;
    bit hold;
    logic [63:0] h_iq;
    logic [OSW-1:0] h_sym;
    logic [3:0] h_sc;
    beats = 0; dp = 0; pulses = 0; cyc = 0; hold = 1'b0; aborted = 1'b0;
    h_iq = '0; h_sym = '0; h_sc = '0;
    total = NSLOT * (NSYM - 1) * nsc;
    while (pulses < NSLOT && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (slot_done) begin
        pulses++;
        chk("slot_done_position", 64'(beats), 64'(pulses * NSYM * nsc));
      end
      if (hold) begin
        chk("stall_hold_valid", 64'(out_valid), 64'd1);
        chk("stall_hold_iq", {out_real, out_img}, h_iq);
        chk("stall_hold_idx", {out_sym, out_sc}, {h_sym, h_sc});
      end
      if (abort_at >= 0 && beats == abort_at) begin
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data_ready", 64'(data_ready), 64'd0);
        chk("async_rst_slot_done", 64'(slot_done), 64'd0);
        aborted = 1'b1;
        data_valid = 1'b0;
        out_ready  = 1'b0;
        return;
      end
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = cyc[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      data_valid = (dp < total) && ((dmode == 0) || ($urandom_range(0, 1) == 1));
      data_real  = dat_re[dp < NDAT ? dp : 0];
      data_img   = dat_im[dp < NDAT ? dp : 0];
      #1;
      if (data_valid && data_ready) dp++;
      hold  = out_valid && !out_ready;
      h_iq  = {out_real, out_img};
      h_sym = out_sym;
      h_sc  = out_sc;
      if (out_valid && out_ready) begin
        chk("beat_iq", {out_real, out_img}, exp_iq(beats, nsc));
        chk("beat_sym", 64'(out_sym), 64'(exp_sym(beats, nsc)));
        chk("beat_sc", 64'(out_sc), 64'(beats % nsc));
        beats++;
      end
    end
    chk("slot_done_count", 64'(pulses), 64'(NSLOT));
    chk("beat_count", 64'(beats), 64'(NSLOT * NSYM * nsc));
    chk("data_consumed", 64'(dp), 64'(total));
    chk("done_out_valid", 64'(out_valid), 64'd0);
    chk("done_data_ready", 64'(data_ready), 64'd0);
    data_valid = 1'b0;
    out_ready  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ab;
    int n_err, n_val, n_rdy, nsc;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_ready", 64'(data_ready), 64'd0);
    chk("rst_slot_done", 64'(slot_done), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_out_iq", {out_real, out_img}, 64'd0);
    chk("rst_out_idx", {out_sym, out_sc}, '0);
    reset = 1'b1;
    @(negedge clk);

    fill_counter();
    do_start(4'd12);
    load_dmrs(12, 1'b1);
    run_slot(12, 0, 0, -1, ab);

    fill_random();
    do_start(4'd3);
    load_dmrs(3, 1'b0);
    run_slot(3, 1, 0, -1, ab);

    data_valid = 1'b1;
    out_ready  = 1'b1;
    do_start(4'd5);
    watch(8, n_err, n_val, n_rdy);
    chk("illegal_nsc_cfg_err", 64'(n_err), 64'd1);
    chk("illegal_nsc_no_valid", 64'(n_val), 64'd0);
    chk("illegal_nsc_no_ready", 64'(n_rdy), 64'd0);
    data_valid = 1'b0;
    out_ready  = 1'b0;

    fill_random();
    do_start(4'd6);
    load_dmrs(4, 1'b1);
    data_valid = 1'b1;
    out_ready  = 1'b1;
    watch(8, n_err, n_val, n_rdy);
    chk("short_load_cfg_err", 64'(n_err), 64'd1);
    chk("short_load_no_valid", 64'(n_val), 64'd0);
    data_valid = 1'b0;
    out_ready  = 1'b0;

    fill_random();
    do_start(4'd3);
    load_dmrs(2, 1'b0);
    watch(6, n_err, n_val, n_rdy);
    chk("short_load2_cfg_err", 64'(n_err), 64'd1);
    chk("short_load2_no_valid", 64'(n_val), 64'd0);

    for (int it = 0; it < 6; it++) begin
      case ($urandom_range(0, 3))
        0: nsc = 1;
        1: nsc = 3;
        2: nsc = 6;
        default: nsc = 12;
      endcase
      fill_random();
      do_start(4'(nsc));
      load_dmrs(nsc, 1'($urandom_range(0, 1)));
      run_slot(nsc, 2, 1, -1, ab);
    end

    fill_random();
    do_start(4'd6);
    load_dmrs(6, 1'b1);
    run_slot(6, 0, 0, 2 * 6, ab);
    chk("reset_abort_reached", 64'(ab), 64'd1);
    repeat (2) @(negedge clk);
    chk("held_reset_no_slot_done", 64'(slot_done), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_out_valid", 64'(out_valid), 64'd0);
    fill_random();
    do_start(4'd3);
    load_dmrs(3, 1'b1);
    run_slot(3, 2, 1, -1, ab);

    fill_counter();
    do_start(4'd1);
    load_dmrs(1, 1'b1);
    run_slot(1, 0, 0, -1, ab);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
